// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit ALU and its issue front-end: default widths,
// opcode constants and the issue controller state encoding.
package alu_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int OPW_DEF   = 3;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_NOT = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_LT  = 3'b110;
  localparam logic [2:0] OP_EQ  = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/alu_issue_ctrl.sv
// Handshaked command/result wrapper around the combinational ALU: result valid one edge after accept.
// Result is held while out_ready is low; a new command is only taken as the previous result retires.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int OPW   = OPW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_num1,
  input  logic [WIDTH-1:0] in_num2,
  input  logic [OPW-1:0]   in_op,
  input  logic             in_acc,
  output logic [WIDTH-1:0] alu_num1,
  output logic [WIDTH-1:0] alu_num2,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_overflow,
  input  logic             alu_cf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_overflow,
  output logic             out_cf,
  output logic             busy
);

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic             accept;

  // out_ready feeds in_ready combinationally so a retiring result frees the slot in the same edge.
  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      alu_num1     <= '0;
      alu_num2     <= '0;
      alu_op       <= '0;
      acc          <= '0;
      out_result   <= '0;
      out_overflow <= 1'b0;
      out_cf       <= 1'b0;
    end else begin
      // acc here is the pre-edge value, i.e. the retiring result in the back-to-back case.
      if (accept) begin
        alu_num1 <= in_acc ? acc : in_num1;
        alu_num2 <= in_num2;
        alu_op   <= in_op;
      end
      case (state)
        IDLE: begin
          if (accept) state <= EXEC;
        end
        EXEC: begin
          out_result   <= alu_result;
          out_overflow <= alu_overflow;
          out_cf       <= alu_cf;
          acc          <= alu_result;
          state        <= DONE;
        end
        DONE: begin
          if (out_ready) state <= in_valid ? EXEC : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl with a behavioural ALU attached and an arithmetic reference model.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, in_acc;
  logic [3:0] in_num1, in_num2;
  logic [2:0] in_op;
  logic [3:0] alu_num1, alu_num2, alu_result;
  logic [2:0] alu_op;
  logic       alu_overflow, alu_cf;
  logic       out_valid, out_ready, out_overflow, out_cf, busy;
  logic [3:0] out_result;

  int checks = 0;
  int errors = 0;
  logic [3:0] acc_m;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.WIDTH(4), .OPW(3)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_num1(in_num1), .in_num2(in_num2), .in_op(in_op), .in_acc(in_acc),
    .alu_num1(alu_num1), .alu_num2(alu_num2), .alu_op(alu_op),
    .alu_result(alu_result), .alu_overflow(alu_overflow), .alu_cf(alu_cf),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_overflow(out_overflow), .out_cf(out_cf),
    .busy(busy)
  );

  // Reference ALU from integer arithmetic; returns {overflow, cf, result}.
  function automatic logic [5:0] alu_ref(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    int ua, ub, sa, sb, s, ss;
    logic [3:0] r;
    logic ov, c;
    ua = int'(a); ub = int'(b);
    sa = (ua >= 8) ? ua - 16 : ua;
    sb = (ub >= 8) ? ub - 16 : ub;
    ov = 1'b0; c = 1'b0; r = 4'd0;
    case (op)
      OP_ADD: begin s = ua + ub; r = 4'(s % 16); c = (s > 15); ss = sa + sb; ov = (ss > 7) || (ss < -8); end
      OP_SUB: begin s = ua - ub + 16; r = 4'(s % 16); c = (ua < ub); ss = sa - sb; ov = (ss > 7) || (ss < -8); end
      OP_NOT: r = 4'(15 - ua);
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_LT:  r = (ua < ub) ? 4'd1 : 4'd0;
      default: r = (ua == ub) ? 4'd1 : 4'd0;
    endcase
    return {ov, c, r};
  endfunction

  logic [5:0] alu_comb;
  always_comb begin
    alu_comb     = alu_ref(alu_num1, alu_num2, alu_op);
    alu_result   = alu_comb[3:0];
    alu_cf       = alu_comb[4];
    alu_overflow = alu_comb[5];
  end

  // Issues one command, waits for its result, optionally stalls, then retires it.
  task automatic run_cmd(input logic [3:0] n1, input logic [3:0] n2, input logic [2:0] op,
                         input logic a, input int stall,
                         output logic [5:0] obs, output int lat);
    int k;
    @(negedge clk);
    in_valid = 1'b1; in_num1 = n1; in_num2 = n2; in_op = op; in_acc = a; out_ready = 1'b0;
    k = 0;
    while (!in_ready && k < 20) begin @(negedge clk); k++; end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
    obs = {out_overflow, out_cf, out_result};
    repeat (stall) @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_num1 = '0; in_num2 = '0; in_op = '0; in_acc = 1'b0;
    acc_m = 4'd0;
    repeat (2) @(negedge clk);
    checks++;
    if ({out_valid, busy, out_result, out_overflow, out_cf} !== 8'h00) begin
      errors++; $display("FAIL reset_outputs got v=%b b=%b r=%h o=%b c=%b want all 0",
                         out_valid, busy, out_result, out_overflow, out_cf);
    end
    checks++;
    if ({alu_num1, alu_num2, alu_op} !== 11'h0) begin
      errors++; $display("FAIL reset_operands got %h %h %h want 0 0 0", alu_num1, alu_num2, alu_op);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_basic_add();
    logic [5:0] obs; int lat;
    run_cmd(4'd3, 4'd4, OP_ADD, 1'b0, 0, obs, lat);
    acc_m = 4'd7;
    checks++;
    if (obs !== {1'b0, 1'b0, 4'd7}) begin errors++; $display("FAIL basic_add got %b want 000111", obs); end
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL basic_latency got %0d want 1", lat); end
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL basic_retire got busy=%b valid=%b want 0 0", busy, out_valid);
    end
  endtask

  task automatic test_overflow_carry();
    logic [5:0] obs; int lat;
    run_cmd(4'd7, 4'd1, OP_ADD, 1'b0, 0, obs, lat);
    checks++;
    if (obs !== 6'b10_1000) begin errors++; $display("FAIL add_7_1 got %b want 101000", obs); end
    run_cmd(4'd15, 4'd1, OP_ADD, 1'b0, 0, obs, lat);
    checks++;
    if (obs !== 6'b01_0000) begin errors++; $display("FAIL add_15_1 got %b want 010000", obs); end
    acc_m = 4'd0;
  endtask

  task automatic test_acc_chain();
    logic [5:0] obs; int lat;
    run_cmd(4'd2, 4'd3, OP_ADD, 1'b0, 0, obs, lat);
    checks++;
    if (obs[3:0] !== 4'd5) begin errors++; $display("FAIL chain_step1 got %0d want 5", obs[3:0]); end
    run_cmd(4'hF, 4'd4, OP_ADD, 1'b1, 1, obs, lat);
    checks++;
    if (obs[3:0] !== 4'd9) begin errors++; $display("FAIL chain_step2 got %0d want 9", obs[3:0]); end
    run_cmd(4'h0, 4'd9, OP_EQ, 1'b1, 0, obs, lat);
    checks++;
    if (obs[3:0] !== 4'd1) begin errors++; $display("FAIL chain_step3 got %0d want 1", obs[3:0]); end
    acc_m = 4'd1;
  endtask

  task automatic test_logic_ops();
    logic [5:0] obs; int lat;
    logic [2:0] ops [3];
    logic [5:0] want [3];
    ops[0] = OP_AND; ops[1] = OP_OR; ops[2] = OP_XOR;
    want[0] = 6'b00_1000; want[1] = 6'b00_1110; want[2] = 6'b00_0110;
    for (int i = 0; i < 3; i++) begin
      run_cmd(4'b1100, 4'b1010, ops[i], 1'b0, 0, obs, lat);
      checks++;
      if (obs !== want[i]) begin errors++; $display("FAIL logic_op%0d got %b want %b", i, obs, want[i]); end
    end
    acc_m = 4'b0110;
  endtask

  task automatic test_back_to_back();
    // A = 9 - 3 = 6 with signed overflow (-7 - 3); B = (acc == 6) -> 1
    @(negedge clk);
    in_valid = 1'b1; in_num1 = 4'd9; in_num2 = 4'd3; in_op = OP_SUB; in_acc = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_num1 = 4'd0; in_num2 = 4'd6; in_op = OP_EQ; in_acc = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || {out_overflow, out_cf, out_result} !== 6'b10_0110) begin
      errors++; $display("FAIL bp_first got v=%b %b%b%h want v=1 100110", out_valid, out_overflow, out_cf, out_result);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || {out_overflow, out_cf, out_result} !== 6'b10_0110) begin
        errors++; $display("FAIL bp_hold%0d got rdy=%b v=%b %b%b%h want rdy=0 v=1 100110",
                           i, in_ready, out_valid, out_overflow, out_cf, out_result);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_path got %b want 1", in_ready); end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL bp_exec got v=%b busy=%b want 0 1", out_valid, busy);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_result !== 4'd1) begin
      errors++; $display("FAIL bp_second got v=%b r=%h want v=1 r=1", out_valid, out_result);
    end
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    acc_m = 4'd1;
  endtask

  task automatic test_reset_midop();
    logic [5:0] obs; int lat; int stale;
    @(negedge clk);
    in_valid = 1'b1; in_num1 = 4'd5; in_num2 = 4'd5; in_op = OP_ADD; in_acc = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL midop_exec got busy=%b want 1", busy); end
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || alu_num1 !== 4'd0) begin
      errors++; $display("FAIL midop_async got v=%b busy=%b n1=%h want 0 0 0", out_valid, busy, alu_num1);
    end
    @(negedge clk);
    rst = 1'b0;
    acc_m = 4'd0;
    stale = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || in_ready !== 1'b1) stale++;
    end
    checks++;
    if (stale != 0) begin errors++; $display("FAIL midop_idle got %0d bad cycles want 0", stale); end
    run_cmd(4'hA, 4'd6, OP_ADD, 1'b1, 0, obs, lat);
    checks++;
    if (obs[3:0] !== 4'd6) begin errors++; $display("FAIL midop_acc got %0d want 6", obs[3:0]); end
    acc_m = 4'd6;
  endtask

  task automatic test_random();
    logic [5:0] obs, exp; int lat;
    logic [3:0] n1, n2; logic [2:0] op; logic a;
    for (int i = 0; i < 40; i++) begin
      n1 = 4'($urandom_range(0, 15));
      n2 = 4'($urandom_range(0, 15));
      op = 3'($urandom_range(0, 7));
      a  = 1'($urandom_range(0, 1));
      exp = alu_ref(a ? acc_m : n1, n2, op);
      run_cmd(n1, n2, op, a, int'($urandom_range(0, 3)), obs, lat);
      acc_m = exp[3:0];
      checks++;
      if (obs !== exp || lat !== 1) begin
        errors++; $display("FAIL rand%0d op=%0d got %b lat=%0d want %b lat=1", i, op, obs, lat, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_overflow_carry();
    test_acc_chain();
    test_logic_ops();
    test_back_to_back();
    test_reset_midop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
